// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and IMem write port bundle for imem_loader
// Purpose: groups the incoming byte stream (rx_*) and the instruction memory
//          write port (mem_*) that imem_loader sits between.
// Ports:   rx_data/rx_valid  byte source -> loader
//          rx_ready          loader -> byte source
//          mem_we/mem_addr/mem_wdata  loader -> IMem
// Modports: master = byte source / IMem side, slave = loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - fills the instruction memory from a length/data/checksum byte stream
// Purpose: receives N, 4*N little-endian data bytes and an XOR checksum byte,
//          writes each assembled word to IMem at byte address 4*index and
//          holds the core in reset until a load has been verified.
// Ports:   clk, rst_n (async, active low)
//          start       single-cycle pulse that begins a load (ignored while busy)
//          bus         slave side of imem_loader_if (rx stream in, IMem write out)
//          core_rst_n  active-low core reset, released only after a good load
//          busy        load in progress
//          done / err  level result of the last load
module imem_loader #(
  parameter int DEPTH     = 16,
  parameter bit BOOT_WAIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t          state, state_d;
  logic [IW-1:0]   word_idx, word_idx_d;
  logic [IW-1:0]   last_idx, last_idx_d;
  logic [1:0]      byte_cnt, byte_cnt_d;
  logic [7:0]      chk, chk_d;
  logic [31:0]     wdata, wdata_d;
  logic [31:0]     addr, addr_d;
  logic            rx_ready_q, mem_we_q;
  logic            core_rst_d;
  logic            accept;

  assign accept        = bus.rx_valid && rx_ready_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;

  always_comb begin
    state_d    = state;
    word_idx_d = word_idx;
    last_idx_d = last_idx;
    byte_cnt_d = byte_cnt;
    chk_d      = chk;
    wdata_d    = wdata;
    addr_d     = addr;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > 32'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            // Store N-1 so the last-word test is a plain equality on word_idx.
            last_idx_d = IW'(bus.rx_data - 8'd1);
            word_idx_d = '0;
            byte_cnt_d = '0;
            chk_d      = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wdata_d[{byte_cnt, 3'b000} +: 8] = bus.rx_data;
          chk_d = chk ^ bus.rx_data;
          if (byte_cnt == 2'd3) begin
            addr_d  = 32'({word_idx, 2'b00});
            state_d = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt + 2'd1;
          end
        end
      end
      S_WRITE: begin
        byte_cnt_d = '0;
        if (word_idx == last_idx) begin
          state_d = S_CHK;
        end else begin
          word_idx_d = word_idx + IW'(1);
          state_d    = S_DATA;
        end
      end
      S_CHK: begin
        if (accept) state_d = (bus.rx_data == chk) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // IDLE is only reachable through reset, so holding keeps the reset value there.
    if (state_d == S_DONE)      core_rst_d = 1'b1;
    else if (state_d == S_IDLE) core_rst_d = core_rst_n;
    else                        core_rst_d = 1'b0;
  end

  // Outputs are registered from the next state so they line up with it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      last_idx   <= '0;
      byte_cnt   <= '0;
      chk        <= '0;
      wdata      <= '0;
      addr       <= '0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= !BOOT_WAIT;
    end else begin
      state      <= state_d;
      word_idx   <= word_idx_d;
      last_idx   <= last_idx_d;
      byte_cnt   <= byte_cnt_d;
      chk        <= chk_d;
      wdata      <= wdata_d;
      addr       <= addr_d;
      rx_ready_q <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
      mem_we_q   <= (state_d == S_WRITE);
      busy       <= (state_d == S_LEN) || (state_d == S_DATA) ||
                    (state_d == S_WRITE) || (state_d == S_CHK);
      done       <= (state_d == S_DONE);
      err        <= (state_d == S_ERR);
      core_rst_n <= core_rst_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic core_rst_n, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(16), .BOOT_WAIT(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus.slave),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int xfer_cnt    = 0;
  int ready_in_we = 0;

  // Inputs change at posedge+1, so the negedge sees stable values for the coming edge.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      if (bus.rx_ready) ready_in_we++;
    end
    if (bus.rx_valid && bus.rx_ready) xfer_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    bus.rx_valid = 1'b0;
    if (!ok) check_eq("byte_accept_timeout", 32'd0, 32'd1);
    repeat (gap) tick();
  endtask

  logic [7:0] good_stream[10] = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
                                  8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

  task automatic send_good(input int gap, input logic [7:0] last_byte);
    for (int i = 0; i < 9; i++) send_byte(good_stream[i], gap);
    send_byte(last_byte, gap);
    tick();
    tick();
  endtask

  task automatic check_good_writes(input string tag, input int base);
    check_eq({tag, "_nwrites"}, 32'(wr_addr_q.size() - base), 32'd2);
    if (wr_addr_q.size() >= base + 2) begin
      check_eq({tag, "_addr0"}, wr_addr_q[base],     32'h0);
      check_eq({tag, "_data0"}, wr_data_q[base],     32'h0000_0013);
      check_eq({tag, "_addr1"}, wr_addr_q[base + 1], 32'h4);
      check_eq({tag, "_data1"}, wr_data_q[base + 1], 32'h0010_0093);
    end
  endtask

  int base;
  int xbase;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) tick();
    check_eq("rst_rx_ready",   32'(bus.rx_ready), 32'd0);
    check_eq("rst_mem_we",     32'(bus.mem_we),   32'd0);
    check_eq("rst_mem_addr",   bus.mem_addr,      32'd0);
    check_eq("rst_mem_wdata",  bus.mem_wdata,     32'd0);
    check_eq("rst_busy",       32'(busy),         32'd0);
    check_eq("rst_done",       32'(done),         32'd0);
    check_eq("rst_err",        32'(err),          32'd0);
    check_eq("rst_core_rst_n", 32'(core_rst_n),   32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("idle_core_rst_n", 32'(core_rst_n), 32'd0);

    // Good load, no gaps
    base = wr_addr_q.size();
    pulse_start();
    check_eq("good_busy", 32'(busy), 32'd1);
    send_good(0, 8'h90);
    check_good_writes("good", base);
    check_eq("good_done", 32'(done),       32'd1);
    check_eq("good_err",  32'(err),        32'd0);
    check_eq("good_core", 32'(core_rst_n), 32'd1);
    check_eq("good_busy_end", 32'(busy),   32'd0);

    // Length 0
    base = wr_addr_q.size();
    pulse_start();
    send_byte(8'h00, 0);
    tick();
    check_eq("len0_err",     32'(err), 32'd1);
    check_eq("len0_nwrites", 32'(wr_addr_q.size() - base), 32'd0);

    // Length 17 > DEPTH
    base = wr_addr_q.size();
    pulse_start();
    send_byte(8'h11, 0);
    repeat (3) tick();
    check_eq("len17_err",     32'(err),        32'd1);
    check_eq("len17_core",    32'(core_rst_n), 32'd0);
    check_eq("len17_nwrites", 32'(wr_addr_q.size() - base), 32'd0);

    // Bad checksum
    base = wr_addr_q.size();
    pulse_start();
    send_good(0, 8'h91);
    check_good_writes("badchk", base);
    check_eq("badchk_err",  32'(err),        32'd1);
    check_eq("badchk_done", 32'(done),       32'd0);
    check_eq("badchk_core", 32'(core_rst_n), 32'd0);

    // Backpressure: valid only every third cycle
    base  = wr_addr_q.size();
    xbase = xfer_cnt;
    pulse_start();
    send_good(2, 8'h90);
    check_good_writes("bp", base);
    check_eq("bp_xfers",       32'(xfer_cnt - xbase), 32'd10);
    check_eq("bp_ready_in_we", 32'(ready_in_we),      32'd0);
    check_eq("bp_done",        32'(done),             32'd1);

    // Reset after byte 5 (first word complete, WRITE in progress)
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(good_stream[i], 0);
    base  = wr_addr_q.size();
    rst_n = 1'b0;
    #1;
    check_eq("mrst_mem_we",   32'(bus.mem_we),   32'd0);
    check_eq("mrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check_eq("mrst_busy",     32'(busy),         32'd0);
    check_eq("mrst_done",     32'(done),         32'd0);
    check_eq("mrst_core",     32'(core_rst_n),   32'd0);
    check_eq("mrst_wdata",    bus.mem_wdata,     32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("mrst_nwrites", 32'(wr_addr_q.size() - base), 32'd0);
    pulse_start();
    send_good(0, 8'h90);
    check_good_writes("mrst_reload", base);
    check_eq("mrst_reload_done", 32'(done), 32'd1);

    // start during DATA is ignored
    base = wr_addr_q.size();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(good_stream[i], 0);
    pulse_start();
    for (int i = 3; i < 10; i++) send_byte(good_stream[i], 0);
    repeat (2) tick();
    check_good_writes("ign", base);
    check_eq("ign_done", 32'(done), 32'd1);

    // start in DONE: reset the core immediately, then overwrite address 0
    base = wr_addr_q.size();
    pulse_start();
    check_eq("restart_core", 32'(core_rst_n), 32'd0);
    check_eq("restart_busy", 32'(busy),       32'd1);
    check_eq("restart_done", 32'(done),       32'd0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h00, 0);
    repeat (2) tick();
    check_eq("restart_nwrites", 32'(wr_addr_q.size() - base), 32'd1);
    if (wr_addr_q.size() > base) begin
      check_eq("restart_addr", wr_addr_q[base], 32'h0);
      check_eq("restart_data", wr_data_q[base], 32'hDDCC_BBAA);
    end
    check_eq("restart_done_end", 32'(done),       32'd1);
    check_eq("restart_core_end", 32'(core_rst_n), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
